// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_id_queue_pkg;

    // Default datapath width for PC and instruction words.
    localparam int unsigned IFQ_XLEN = 32;

    // addi x0,x0,0 -- presented on d_inst whenever the queue is empty.
    localparam logic [31:0] IFQ_NOP_INST = 32'h0000_0013;

    // Number of queue entries; occupancy and the 1-bit pointers are sized for this.
    localparam int unsigned IFQ_DEPTH = 2;

    typedef logic [1:0] occ_t;

    localparam occ_t IFQ_OCC_FULL = occ_t'(IFQ_DEPTH);

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue.sv
// Two-entry IF->ID skid queue of {pc, inst}; optional perf counters under IFQ_PERF_CNT_EN.
// Latency: 1 cycle from a push edge to the entry appearing on d_*.
// Backpressure: f_ready = !full from registered state only; no combinational path from d_ready.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned      XLEN     = IFQ_XLEN,
    parameter logic [XLEN-1:0]  NOP_INST = XLEN'(IFQ_NOP_INST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [XLEN-1:0]  f_pc,
    input  logic [XLEN-1:0]  f_inst,
    output logic             f_ready,
    input  logic             flush,
    input  logic             d_ready,
    output logic             d_valid,
    output logic [XLEN-1:0]  d_pc,
    output logic [XLEN-1:0]  d_inst,
`ifdef IFQ_PERF_CNT_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
`endif
    output logic [1:0]       occupancy
);

    // Entry storage; contents are only meaningful while counted by occ_q.
    logic [XLEN-1:0] pc_q   [IFQ_DEPTH];
    logic [XLEN-1:0] inst_q [IFQ_DEPTH];

    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;
    occ_t occ_q,    occ_d;

    logic push;
    logic pop;

    // Handshake qualifiers; flush kills both transfers in the cycle it is seen.
    always_comb begin
        push = f_valid && f_ready && !flush;
        pop  = d_valid && d_ready && !flush;
    end

    // Outputs derive purely from registered state.
    always_comb begin
        f_ready   = (occ_q != IFQ_OCC_FULL);
        d_valid   = (occ_q != 2'd0);
        occupancy = occ_q;
        d_pc      = '0;
        d_inst    = NOP_INST;
        if (d_valid) begin
            d_pc   = pc_q[rd_ptr_q];
            d_inst = inst_q[rd_ptr_q];
        end
    end

    // Next-state for pointers and occupancy; flush returns the queue to its empty origin.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state register; reset outranks flush, push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry write on accepted push only, so held entries never change under stall.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_q[wr_ptr_q]   <= f_pc;
            inst_q[wr_ptr_q] <= f_inst;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running wrap-around event counters for fetch stalls and redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (f_valid && !f_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule : if_id_queue
